// File: rtl/i2c_byte_core_if.sv
// i2c_byte_core_if
//   Command handshake and open-drain pad signals between the upstream
//   accelerometer controller / pad environment and the I2C byte engine.
//   master : upstream side (drives commands, supplies the SDA pad level)
//   slave  : the byte engine (consumes commands, drives status and pad enables)
//   Signals:
//     data_valid, rw, slave_addr[6:0], reg_addr[7:0], reg_data[7:0] : command
//     core_busy, rd_data[7:0], rd_valid, ack_err                     : status
//     scl_oe, sda_oe (1 = pull low), sda_in (SDA pad level)          : bus
interface i2c_byte_core_if;
  logic       data_valid;
  logic       rw;
  logic [6:0] slave_addr;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       core_busy;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       ack_err;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;

  modport master (
    output data_valid, rw, slave_addr, reg_addr, reg_data, sda_in,
    input  core_busy, rd_data, rd_valid, ack_err, scl_oe, sda_oe
  );

  modport slave (
    input  data_valid, rw, slave_addr, reg_addr, reg_data, sda_in,
    output core_busy, rd_data, rd_valid, ack_err, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_byte_core.sv
// i2c_byte_core
//   Single-master I2C bit engine. One command per handshake: register write
//   (S, addr+W, reg, data, P) or single-byte register read
//   (S, addr+W, reg, Sr, addr+R, data, NACK, P). No clock stretching.
//   Each bit slot is four phases of QTR clocks; SCL is low in ph0/ph3 and
//   released in ph1/ph2. SDA is sampled on the last clock of ph1.
//   Ports:
//     clk  : system clock (posedge)
//     rst  : asynchronous active-low reset
//     bus  : i2c_byte_core_if.slave (command, status and pad signals)
module i2c_byte_core #(
  parameter int CLK_HZ = 50_000_000,
  parameter int I2C_HZ = 100_000
) (
  input  logic           clk,
  input  logic           rst,
  i2c_byte_core_if.slave bus
);

  localparam int QTR = CLK_HZ / (4 * I2C_HZ);
  localparam int CW  = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(QTR - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    START  = 4'd1,
    ADDR_W = 4'd2,
    REG    = 4'd3,
    DATA_W = 4'd4,
    RSTART = 4'd5,
    ADDR_R = 4'd6,
    DATA_R = 4'd7,
    STOP   = 4'd8,
    FREE   = 4'd9
  } state_t;

  state_t        state_r;
  logic [1:0]    ph_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    bit_r;      // 0..7 data bits, 8 = ACK slot
  logic [7:0]    tx_r;       // outgoing byte, MSB is the bit on the wire
  logic [7:0]    rx_r;
  logic          rw_r;
  logic [6:0]    sa_r;
  logic [7:0]    ra_r;
  logic [7:0]    wd_r;
  logic          nack_r;     // NACK seen in the current command
  logic          busy_r;
  logic [7:0]    rd_data_r;
  logic          rd_valid_r;
  logic          ack_err_r;
  logic          scl_oe_r;
  logic          sda_oe_r;

  logic          last_clk_s;
  logic          slot_end_s;
  logic          sample_s;
  logic          ack_slot_s;
  logic          is_tx_byte_s;
  logic          scl_pull_s;
  logic          sda_pull_s;

  // Phase timing strobes and slot classification
  always_comb begin
    last_clk_s   = (cnt_r == CNT_LAST);
    slot_end_s   = last_clk_s && (ph_r == 2'd3);
    sample_s     = last_clk_s && (ph_r == 2'd1);
    ack_slot_s   = (bit_r == 4'd8);
    is_tx_byte_s = (state_r == ADDR_W) || (state_r == REG) ||
                   (state_r == DATA_W) || (state_r == ADDR_R);
  end

  // Pad levels for the current slot/phase; registered one clock later
  always_comb begin
    scl_pull_s = 1'b0;
    sda_pull_s = 1'b0;
    case (state_r)
      START: begin
        scl_pull_s = (ph_r == 2'd3);
        sda_pull_s = ph_r[1];
      end
      ADDR_W, REG, DATA_W, ADDR_R: begin
        scl_pull_s = (ph_r == 2'd0) || (ph_r == 2'd3);
        sda_pull_s = !ack_slot_s && !tx_r[7];
      end
      DATA_R: begin
        // master releases SDA for data and for its final NACK
        scl_pull_s = (ph_r == 2'd0) || (ph_r == 2'd3);
        sda_pull_s = 1'b0;
      end
      RSTART: begin
        scl_pull_s = (ph_r == 2'd0) || (ph_r == 2'd3);
        sda_pull_s = ph_r[1];
      end
      STOP: begin
        scl_pull_s = (ph_r == 2'd0);
        sda_pull_s = !ph_r[1];
      end
      default: begin
        scl_pull_s = 1'b0;
        sda_pull_s = 1'b0;
      end
    endcase
  end

  // Command sequencer: phase timing, shifters, status and pad registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      ph_r       <= 2'd0;
      cnt_r      <= '0;
      bit_r      <= 4'd0;
      tx_r       <= 8'h00;
      rx_r       <= 8'h00;
      rw_r       <= 1'b0;
      sa_r       <= 7'h00;
      ra_r       <= 8'h00;
      wd_r       <= 8'h00;
      nack_r     <= 1'b0;
      busy_r     <= 1'b0;
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
      ack_err_r  <= 1'b0;
      scl_oe_r   <= 1'b0;
      sda_oe_r   <= 1'b0;
    end else begin
      rd_valid_r <= 1'b0;
      scl_oe_r   <= scl_pull_s;
      sda_oe_r   <= sda_pull_s;
      if (state_r == IDLE) begin
        ph_r  <= 2'd0;
        cnt_r <= '0;
        bit_r <= 4'd0;
        if (bus.data_valid) begin
          rw_r      <= bus.rw;
          sa_r      <= bus.slave_addr;
          ra_r      <= bus.reg_addr;
          wd_r      <= bus.reg_data;
          busy_r    <= 1'b1;
          ack_err_r <= 1'b0;
          nack_r    <= 1'b0;
          state_r   <= START;
        end
      end else begin
        if (last_clk_s) begin
          cnt_r <= '0;
          ph_r  <= ph_r + 2'd1;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end

        if (sample_s) begin
          if (is_tx_byte_s && ack_slot_s && bus.sda_in) begin
            nack_r    <= 1'b1;
            ack_err_r <= 1'b1;
          end
          if ((state_r == DATA_R) && !ack_slot_s) begin
            rx_r <= {rx_r[6:0], bus.sda_in};
          end
        end

        if (slot_end_s) begin
          case (state_r)
            START: begin
              state_r <= ADDR_W;
              tx_r    <= {sa_r, 1'b0};
              bit_r   <= 4'd0;
            end
            ADDR_W, REG, DATA_W, ADDR_R, DATA_R: begin
              if (!ack_slot_s) begin
                bit_r <= bit_r + 4'd1;
                tx_r  <= {tx_r[6:0], 1'b0};
              end else begin
                bit_r <= 4'd0;
                if (nack_r) begin
                  state_r <= STOP;
                end else begin
                  case (state_r)
                    ADDR_W: begin
                      state_r <= REG;
                      tx_r    <= ra_r;
                    end
                    REG: begin
                      if (rw_r) begin
                        state_r <= RSTART;
                      end else begin
                        state_r <= DATA_W;
                        tx_r    <= wd_r;
                      end
                    end
                    ADDR_R:  state_r <= DATA_R;
                    default: state_r <= STOP;
                  endcase
                end
              end
            end
            RSTART: begin
              state_r <= ADDR_R;
              tx_r    <= {sa_r, 1'b1};
              bit_r   <= 4'd0;
            end
            STOP: state_r <= FREE;
            FREE: begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              if (rw_r && !nack_r) begin
                rd_data_r  <= rx_r;
                rd_valid_r <= 1'b1;
              end
            end
            default: state_r <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.core_busy = busy_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.ack_err   = ack_err_r;
  assign bus.scl_oe    = scl_oe_r;
  assign bus.sda_oe    = sda_oe_r;

endmodule
